ocx_tlx_credit_return_gen: RTL



---
 rtl/ocx_tlx_credit_return_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ocx_tlx_credit_return_gen.sv
// TLX transmit-side credit return: accumulates freed receive credits and sends
// return_tl_credits control-slot packets to the framer over a req/gnt handshake.
module ocx_tlx_credit_return_gen #(
    parameter int INIT_VC0  = 16,
    parameter int INIT_VC1  = 16,
    parameter int INIT_DCP0 = 32,
    parameter int INIT_DCP1 = 32,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic        tlx_clk,
    input  logic        reset_n,
    input  logic        link_up,
    input  logic        vc0_release,
    input  logic        vc1_release,
    input  logic        dcp0_release,
    input  logic        dcp1_release,
    output logic        credit_req,
    input  logic        credit_gnt,
    output logic [55:0] credit_pkt,
    output logic        credit_pkt_v,
    output logic        credit_ovf,
    output logic [1:0]  state_dbg
);

    // Handshake: credit_req stays high from the cycle after the trigger until
    // a cycle with credit_gnt=1 (packet taken) or link_up=0 (request withdrawn).
    // The packet appears on credit_pkt with credit_pkt_v the cycle after the grant.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
    localparam logic [7:0] THR  = 8'(THRESHOLD);

    state_t      state_q, state_d;
    logic [7:0]  acc_q [4];
    logic [7:0]  acc_d [4];
    logic [7:0]  snd   [4];
    logic [7:0]  timer_q, timer_d;
    logic        credit_req_q, credit_req_d;
    logic [55:0] credit_pkt_q, credit_pkt_d;
    logic        credit_pkt_v_q, credit_pkt_v_d;
    logic        credit_ovf_q, credit_ovf_d;
    logic [3:0]  rel;
    logic        grant;
    logic        any_nz;
    logic        over_thr;

    // Index order everywhere: 0=VC0, 1=VC1, 2=DCP0, 3=DCP1.
    always_comb begin
        rel      = {dcp1_release, dcp0_release, vc1_release, vc0_release};
        grant    = (state_q == REQ) && link_up && credit_gnt;
        any_nz   = 1'b0;
        over_thr = 1'b0;
        credit_ovf_d = credit_ovf_q;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] fmax;
            logic [7:0] base;
            fmax   = (i < 2) ? 8'd15 : 8'd63;
            snd[i] = (acc_q[i] > fmax) ? fmax : acc_q[i];
            base   = grant ? (acc_q[i] - snd[i]) : acc_q[i];
            // A release landing on a grant cycle is added after the subtraction.
            if (rel[i]) begin
                if (base == 8'hFF) begin
                    credit_ovf_d = 1'b1;
                end else begin
                    base = base + 8'd1;
                end
            end
            acc_d[i] = base;
            any_nz   = any_nz | (acc_q[i] != 8'd0);
            over_thr = over_thr | (acc_q[i] >= THR);
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (grant || !any_nz) begin
            timer_d = 8'd0;
        end else if ((state_q == IDLE) && link_up && (timer_q != TLIM)) begin
            timer_d = timer_q + 8'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_pkt_d   = credit_pkt_q;
        credit_pkt_v_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (link_up && (over_thr || ((timer_q == TLIM) && any_nz))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!link_up) begin
                    state_d = IDLE;
                end else if (credit_gnt) begin
                    state_d        = SEND;
                    credit_pkt_v_d = 1'b1;
                    credit_pkt_d   = {12'd0, snd[3][5:0], snd[2][5:0], 16'd0,
                                      snd[1][3:0], snd[0][3:0], 8'h08};
                end
            end
            SEND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        credit_req_d = (state_d == REQ);
    end

    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            acc_q[0]       <= 8'(INIT_VC0);
            acc_q[1]       <= 8'(INIT_VC1);
            acc_q[2]       <= 8'(INIT_DCP0);
            acc_q[3]       <= 8'(INIT_DCP1);
            timer_q        <= 8'd0;
            credit_req_q   <= 1'b0;
            credit_pkt_q   <= 56'd0;
            credit_pkt_v_q <= 1'b0;
            credit_ovf_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
            timer_q        <= timer_d;
            credit_req_q   <= credit_req_d;
            credit_pkt_q   <= credit_pkt_d;
            credit_pkt_v_q <= credit_pkt_v_d;
            credit_ovf_q   <= credit_ovf_d;
        end
    end

    assign credit_req   = credit_req_q;
    assign credit_pkt   = credit_pkt_q;
    assign credit_pkt_v = credit_pkt_v_q;
    assign credit_ovf   = credit_ovf_q;
    assign state_dbg    = state_q;

endmodule
